store_aligner: RTL and testbench
================================

# store_aligner

Memory-stage store path unit that converts a register-file store (SW/SH/SB) into a word-aligned data-memory write with byte enables and lane-replicated data. It is the write-side counterpart of the load/immediate extension logic: it narrows and positions data into the word rather than widening it. It sits between the MEM pipeline register and the data-memory port, and holds each request until the memory acknowledges it. It stalls the pipeline while busy and flags misaligned stores as an address-error exception.

## Interface
Parameters:
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  rising-edge clock; the block has exactly one clock.
- reset_n  in  1  reset, asynchronous, active-low.
- st_valid  in  1  a store is presented this cycle.
- st_op  in  2  store width: 00 SW, 01 SH, 10 SB, 11 reserved.
- st_addr  in  ADDR_W  byte address.
- st_wdata  in  32  rt register value.
- st_ready  out  1  store accepted on this edge if st_valid; combinational from state.
- dm_req  out  1  memory write request, registered.
- dm_addr  out  ADDR_W  word address, {st_addr[ADDR_W-1:2],2'b00}, registered.
- dm_wdata  out  32  lane-positioned data, registered.
- dm_be  out  4  byte enables, bit i = byte lane i (little-endian), registered.
- dm_ack  in  1  memory accepted the request on this edge.
- exc_ades  out  1  one-cycle address-error-on-store pulse, registered.
- badvaddr  out  ADDR_W  faulting byte address, held until the next exception.

## Operation
- Handshake: a store transfers when st_valid && st_ready. A memory write completes when dm_req && dm_ack.
- States:
  - IDLE: st_ready=1.
  - REQ: dm_req=1, held with stable addr/data/be until dm_ack.
- Transitions:
  - IDLE -> REQ on an accepted aligned store.
  - REQ -> IDLE on dm_ack when no next store is pending.
  - A misaligned store does not leave IDLE.
- Lane rules for SB, where k = st_addr[1:0]:
  - dm_be = 4'b0001<<k.
  - dm_wdata = {4{st_wdata[7:0]}}.
- Lane rules for SH:
  - st_addr[1]=0: be=0011; st_addr[1]=1: be=1100.
  - dm_wdata = {2{st_wdata[15:0]}}.
- Lane rules for SW: be=1111, dm_wdata=st_wdata.
- Misaligned: SH with st_addr[0]=1, SW with st_addr[1:0]!=00, or st_op=11.
  - The store is accepted (consumed) and no dm_req is issued.
  - exc_ades=1 for exactly one cycle and badvaddr=st_addr.
- Bytes outside dm_be carry the replicated value; memory must honour dm_be.

## Timing
- Reset values:
  - dm_req=0, dm_addr=0, dm_wdata=0, dm_be=0, exc_ades=0, badvaddr=0.
  - State=IDLE, so st_ready=1.
- Latency: a store accepted at edge N produces dm_req=1 from cycle N+1 (or exc_ades=1 in cycle N+1).
- dm_ack sampled in the same cycle dm_req rises completes the write in one cycle. dm_req=0 in the following cycle unless a store is pending.
- While dm_req=1 && dm_ack=0, outputs are frozen (verification: no change in dm_addr/dm_wdata/dm_be).
- dm_ack while dm_req=0 is ignored.
- Throughput without the buffer: one store per 2 cycles at best, since st_ready=0 throughout REQ.
- Reset asserted mid-request: dm_req drops asynchronously, the in-flight store is discarded and any buffered store is cleared.

## Configuration
- Macro STORE_SKID_EN.
- Undefined: behaviour exactly as above; st_ready = (state==IDLE).
- Defined: adds a one-entry pending buffer holding the already-aligned addr/data/be; st_ready = !buffer_full.
  - A store accepted in REQ without a simultaneous dm_ack goes to the buffer.
  - On dm_ack with the buffer full, the buffer moves into the output registers and dm_req stays 1 for the next cycle (back-to-back, 1 store/cycle when dm_ack is constantly high).
  - Accept and dm_ack on the same edge with the buffer empty: the new store loads directly into the output registers.
  - A misaligned store arriving in REQ still pulses exc_ades in the next cycle and is not buffered.

## Test plan
- Reset: hold reset_n=0 -> all outputs 0, st_ready=1; release with st_valid=0 -> no dm_req.
- SB addr=0x0000_1003, wdata=0x1234_56AB -> next cycle dm_req=1, dm_addr=0x0000_1000, dm_be=1000, dm_wdata=0xABAB_ABAB.
- SH addr=0x0000_2002, wdata=0xDEAD_BEEF, with dm_ack held 0 for 3 cycles -> dm_be=1100, dm_wdata=0xBEEF_BEEF stable for 4 cycles, st_ready=0, dm_req=0 after the ack.
- SW addr=0x0000_3002 -> no dm_req; exc_ades=1 for one cycle; badvaddr=0x0000_3002; st_ready stays 1.
- reset_n=0 while dm_req=1 -> dm_req=0 immediately; after release a new SW at 0x10 is issued normally with be=1111.
- STORE_SKID_EN, three SWs on consecutive cycles with dm_ack=1 -> dm_req high for 3 consecutive cycles with addresses in order and st_ready never 0.

Source files
------------

// File: rtl/store_aligner.sv
// Store path aligner: turns SW/SH/SB into a word-aligned, byte-enabled memory write.
// Optional one-entry pending buffer for back-to-back stores: define STORE_SKID_EN.
module store_aligner #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              st_valid,
    input  logic [1:0]        st_op,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_wdata,
    output logic              st_ready,
    output logic              dm_req,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic [3:0]        dm_be,
    input  logic              dm_ack,
    output logic              exc_ades,
    output logic [ADDR_W-1:0] badvaddr
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] al_addr;
    logic [31:0]       al_data;
    logic [3:0]        al_be;
    logic              misal;
    logic              accept;
    logic              accept_ok;
    logic              accept_bad;

    always_comb begin
        al_addr = {st_addr[ADDR_W-1:2], 2'b00};
        al_data = st_wdata;
        al_be   = '0;
        misal   = 1'b0;
        case (st_op)
            2'b00: begin
                al_be = 4'b1111;
                misal = (st_addr[1:0] != 2'b00);
            end
            2'b01: begin
                al_be   = st_addr[1] ? 4'b1100 : 4'b0011;
                al_data = {2{st_wdata[15:0]}};
                misal   = st_addr[0];
            end
            2'b10: begin
                al_be   = 4'b0001 << st_addr[1:0];
                al_data = {4{st_wdata[7:0]}};
            end
            default: misal = 1'b1;
        endcase
    end

`ifdef STORE_SKID_EN
    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_data;
    logic [3:0]        buf_be;

    assign st_ready = !buf_full;
`else
    assign st_ready = (state == IDLE);
`endif

    assign accept     = st_valid && st_ready;
    assign accept_ok  = accept && !misal;
    assign accept_bad = accept && misal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            dm_req   <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_be    <= '0;
            exc_ades <= 1'b0;
            badvaddr <= '0;
`ifdef STORE_SKID_EN
            buf_full <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
            buf_be   <= '0;
`endif
        end else begin
            exc_ades <= accept_bad;
            if (accept_bad) begin
                badvaddr <= st_addr;
            end
            case (state)
                IDLE: begin
                    if (accept_ok) begin
                        state    <= REQ;
                        dm_req   <= 1'b1;
                        dm_addr  <= al_addr;
                        dm_wdata <= al_data;
                        dm_be    <= al_be;
                    end
                end
                default: begin
`ifdef STORE_SKID_EN
                    // Buffered store has priority; a new store can only be accepted when the buffer is empty.
                    if (dm_ack) begin
                        if (buf_full) begin
                            buf_full <= 1'b0;
                            dm_addr  <= buf_addr;
                            dm_wdata <= buf_data;
                            dm_be    <= buf_be;
                        end else if (accept_ok) begin
                            dm_addr  <= al_addr;
                            dm_wdata <= al_data;
                            dm_be    <= al_be;
                        end else begin
                            state  <= IDLE;
                            dm_req <= 1'b0;
                        end
                    end else if (accept_ok) begin
                        buf_full <= 1'b1;
                        buf_addr <= al_addr;
                        buf_data <= al_data;
                        buf_be   <= al_be;
                    end
`else
                    if (dm_ack) begin
                        state  <= IDLE;
                        dm_req <= 1'b0;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_aligner.sv
// Directed self-checking bench for store_aligner (default build; skid scenario when STORE_SKID_EN is defined).
module tb_store_aligner;

    logic        clk;
    logic        reset_n;
    logic        st_valid;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        st_ready;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic        exc_ades;
    logic [31:0] badvaddr;

    int checks;
    int failures;

    store_aligner #(.ADDR_W(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .st_valid (st_valid),
        .st_op    (st_op),
        .st_addr  (st_addr),
        .st_wdata (st_wdata),
        .st_ready (st_ready),
        .dm_req   (dm_req),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_be    (dm_be),
        .dm_ack   (dm_ack),
        .exc_ades (exc_ades),
        .badvaddr (badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = addr;
        st_wdata = data;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        st_valid = 1'b0;
        st_op    = 2'b00;
        st_addr  = '0;
        st_wdata = '0;
        dm_ack   = 1'b0;
        #12;
        checks++;
        if ({dm_req, dm_addr, dm_wdata, dm_be, exc_ades, badvaddr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b addr=%h data=%h be=%b exc=%b bad=%h, required all zero",
                     dm_req, dm_addr, dm_wdata, dm_be, exc_ades, badvaddr);
        end
        checks++;
        if (st_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b, required 1", st_ready);
        end
        step();
        reset_n = 1'b1;
        step();
        step();
        checks++;
        if (dm_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: dm_req=%b, required 0", dm_req);
        end
    endtask

    task automatic test_sb_lanes();
        logic [31:0] addrs [4];
        logic [31:0] datas [4];
        logic [31:0] exp_d [4];
        logic [3:0]  exp_be [4];
        logic [31:0] exp_a [4];
        addrs[0] = 32'h0000_1003; datas[0] = 32'h1234_56AB; exp_d[0] = 32'hABAB_ABAB; exp_be[0] = 4'b1000; exp_a[0] = 32'h0000_1000;
        addrs[1] = 32'h0000_1000; datas[1] = 32'h0000_00C5; exp_d[1] = 32'hC5C5_C5C5; exp_be[1] = 4'b0001; exp_a[1] = 32'h0000_1000;
        addrs[2] = 32'h0000_1001; datas[2] = 32'hFFFF_FF3C; exp_d[2] = 32'h3C3C_3C3C; exp_be[2] = 4'b0010; exp_a[2] = 32'h0000_1000;
        addrs[3] = 32'h0000_1FFE; datas[3] = 32'h8765_4301; exp_d[3] = 32'h0101_0101; exp_be[3] = 4'b0100; exp_a[3] = 32'h0000_1FFC;
        for (int i = 0; i < 4; i++) begin
            present(2'b10, addrs[i], datas[i]);
            checks++;
            if (st_ready !== 1'b1) begin
                failures++;
                $display("FAIL sb_ready[%0d]: got %b, required 1", i, st_ready);
            end
            step();
            st_valid = 1'b0;
            checks++;
            if ({dm_req, dm_addr, dm_be, dm_wdata} !== {1'b1, exp_a[i], exp_be[i], exp_d[i]}) begin
                failures++;
                $display("FAIL sb_lane[%0d]: req=%b addr=%h be=%b data=%h, required 1 %h %b %h",
                         i, dm_req, dm_addr, dm_be, dm_wdata, exp_a[i], exp_be[i], exp_d[i]);
            end
            dm_ack = 1'b1;
            step();
            dm_ack = 1'b0;
            checks++;
            if ({dm_req, st_ready} !== 2'b01) begin
                failures++;
                $display("FAIL sb_done[%0d]: req=%b ready=%b, required req=0 ready=1", i, dm_req, st_ready);
            end
        end
    endtask

    task automatic test_sh_stall();
        present(2'b01, 32'h0000_2002, 32'hDEAD_BEEF);
        step();
        st_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({dm_req, dm_addr, dm_be, dm_wdata} !== {1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF}) begin
                failures++;
                $display("FAIL sh_hold[%0d]: req=%b addr=%h be=%b data=%h, required 1 00002000 1100 beefbeef",
                         c, dm_req, dm_addr, dm_be, dm_wdata);
            end
`ifndef STORE_SKID_EN
            checks++;
            if (st_ready !== 1'b0) begin
                failures++;
                $display("FAIL sh_busy[%0d]: st_ready=%b, required 0", c, st_ready);
            end
`endif
            if (c == 3) dm_ack = 1'b1;
            step();
        end
        dm_ack = 1'b0;
        checks++;
        if ({dm_req, st_ready} !== 2'b01) begin
            failures++;
            $display("FAIL sh_done: req=%b ready=%b, required req=0 ready=1", dm_req, st_ready);
        end
        present(2'b01, 32'h0000_2000, 32'h0000_A55A);
        step();
        st_valid = 1'b0;
        checks++;
        if ({dm_req, dm_be, dm_wdata} !== {1'b1, 4'b0011, 32'hA55A_A55A}) begin
            failures++;
            $display("FAIL sh_low: req=%b be=%b data=%h, required 1 0011 a55aa55a", dm_req, dm_be, dm_wdata);
        end
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
    endtask

    task automatic test_misaligned();
        logic [1:0]  ops   [3];
        logic [31:0] addrs [3];
        ops[0] = 2'b00; addrs[0] = 32'h0000_3002;
        ops[1] = 2'b01; addrs[1] = 32'h0000_3001;
        ops[2] = 2'b11; addrs[2] = 32'h0000_3004;
        for (int i = 0; i < 3; i++) begin
            present(ops[i], addrs[i], 32'h5555_AAAA);
            step();
            st_valid = 1'b0;
            checks++;
            if ({dm_req, exc_ades, st_ready, badvaddr} !== {3'b011, addrs[i]}) begin
                failures++;
                $display("FAIL misalign[%0d]: req=%b exc=%b ready=%b bad=%h, required req=0 exc=1 ready=1 bad=%h",
                         i, dm_req, exc_ades, st_ready, badvaddr, addrs[i]);
            end
            step();
            checks++;
            if ({dm_req, exc_ades, badvaddr} !== {2'b00, addrs[i]}) begin
                failures++;
                $display("FAIL misalign_pulse[%0d]: req=%b exc=%b bad=%h, required req=0 exc=0 bad=%h",
                         i, dm_req, exc_ades, badvaddr, addrs[i]);
            end
        end
    endtask

    task automatic test_ack_idle();
        dm_ack = 1'b1;
        step();
        step();
        dm_ack = 1'b0;
        checks++;
        if ({dm_req, st_ready, dm_addr} !== {2'b01, 32'h0000_2000}) begin
            failures++;
            $display("FAIL ack_idle: req=%b ready=%b addr=%h, required req=0 ready=1 addr=00002000",
                     dm_req, st_ready, dm_addr);
        end
    endtask

    task automatic test_reset_mid();
        present(2'b00, 32'h0000_0020, 32'hCAFE_F00D);
        step();
        st_valid = 1'b0;
        checks++;
        if (dm_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre: dm_req=%b, required 1", dm_req);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({dm_req, dm_be, dm_addr, st_ready} !== {1'b0, 4'b0000, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL rst_mid_async: req=%b be=%b addr=%h ready=%b, required 0 0000 0 1",
                     dm_req, dm_be, dm_addr, st_ready);
        end
        step();
        reset_n = 1'b1;
        step();
        present(2'b00, 32'h0000_0010, 32'h1122_3344);
        step();
        st_valid = 1'b0;
        checks++;
        if ({dm_req, dm_addr, dm_be, dm_wdata} !== {1'b1, 32'h0000_0010, 4'b1111, 32'h1122_3344}) begin
            failures++;
            $display("FAIL rst_mid_after: req=%b addr=%h be=%b data=%h, required 1 00000010 1111 11223344",
                     dm_req, dm_addr, dm_be, dm_wdata);
        end
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        checks++;
        if (dm_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_done: dm_req=%b, required 0", dm_req);
        end
    endtask

`ifndef STORE_SKID_EN
    task automatic test_back_to_back();
        dm_ack = 1'b1;
        present(2'b00, 32'h0000_0040, 32'hAAAA_0001);
        step();
        checks++;
        if ({dm_req, st_ready, dm_addr} !== {2'b10, 32'h0000_0040}) begin
            failures++;
            $display("FAIL b2b_first: req=%b ready=%b addr=%h, required 1 0 00000040", dm_req, st_ready, dm_addr);
        end
        present(2'b00, 32'h0000_0044, 32'hAAAA_0002);
        step();
        checks++;
        if ({dm_req, st_ready} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_gap: req=%b ready=%b, required 0 1", dm_req, st_ready);
        end
        step();
        st_valid = 1'b0;
        checks++;
        if ({dm_req, dm_addr, dm_wdata} !== {1'b1, 32'h0000_0044, 32'hAAAA_0002}) begin
            failures++;
            $display("FAIL b2b_second: req=%b addr=%h data=%h, required 1 00000044 aaaa0002", dm_req, dm_addr, dm_wdata);
        end
        step();
        dm_ack = 1'b0;
        checks++;
        if (dm_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done: dm_req=%b, required 0", dm_req);
        end
    endtask
`else
    task automatic test_skid();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0000_0050;
        addrs[1] = 32'h0000_0054;
        addrs[2] = 32'h0000_0058;
        dm_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(2'b00, addrs[i], 32'hBB00_0000 + i);
            checks++;
            if (st_ready !== 1'b1) begin
                failures++;
                $display("FAIL skid_ready[%0d]: st_ready=%b, required 1", i, st_ready);
            end
            step();
            checks++;
            if ({dm_req, dm_addr} !== {1'b1, addrs[i]}) begin
                failures++;
                $display("FAIL skid_stream[%0d]: req=%b addr=%h, required 1 %h", i, dm_req, dm_addr, addrs[i]);
            end
        end
        st_valid = 1'b0;
        step();
        dm_ack = 1'b0;
        checks++;
        if (dm_req !== 1'b0) begin
            failures++;
            $display("FAIL skid_drain: dm_req=%b, required 0", dm_req);
        end
        present(2'b00, 32'h0000_0060, 32'h0000_0060);
        step();
        present(2'b10, 32'h0000_0065, 32'h0000_0077);
        step();
        st_valid = 1'b0;
        checks++;
        if ({dm_req, st_ready, dm_addr} !== {2'b10, 32'h0000_0060}) begin
            failures++;
            $display("FAIL skid_buffered: req=%b ready=%b addr=%h, required 1 0 00000060", dm_req, st_ready, dm_addr);
        end
        dm_ack = 1'b1;
        step();
        checks++;
        if ({dm_req, dm_addr, dm_be, dm_wdata, st_ready} !== {1'b1, 32'h0000_0064, 4'b0010, 32'h7777_7777, 1'b1}) begin
            failures++;
            $display("FAIL skid_unload: req=%b addr=%h be=%b data=%h ready=%b, required 1 00000064 0010 77777777 1",
                     dm_req, dm_addr, dm_be, dm_wdata, st_ready);
        end
        step();
        dm_ack = 1'b0;
        checks++;
        if (dm_req !== 1'b0) begin
            failures++;
            $display("FAIL skid_unload_done: dm_req=%b, required 0", dm_req);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sb_lanes();
        test_sh_stall();
        test_misaligned();
        test_ack_idle();
        test_reset_mid();
`ifndef STORE_SKID_EN
        test_back_to_back();
`else
        test_skid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
